if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the pipelined MIPS CPU. It owns the PC, issues requests to a variable-latency instruction memory, and drives the IF/ID pipeline register that the hazard unit reads. It obeys the hazard unit's PCWre/IFID_Stall and the ID stage's branch/jump redirect. It also buffers a returned instruction while ID is stalled, so no fetch is repeated or lost.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
PCWre  in  1  PC write enable from hazard unit; 0 holds PC.
IFID_Stall  in  1  1 holds the IF/ID register contents.
Redirect  in  1  branch/jump taken, resolved in ID; flushes IF.
RedirectPC  in  32  target address; bits [1:0] forced to 0.
ImemReq  out  1  fetch request to instruction memory.
ImemAddr  out  32  fetch address; stable while ImemReq=1 and ImemRdy=0.
ImemRdy  in  1  memory response valid this cycle.
ImemData  in  32  instruction word, valid when ImemRdy=1.
Instr_IFID  out  32  IF/ID instruction.
PCPlus4_IFID  out  32  IF/ID PC+4.
Valid_IFID  out  1  0 = bubble.
Opcode_IFID  out  6  Instr_IFID[31:26].
Func_IFID  out  6  Instr_IFID[5:0].
RsAddr_IFID  out  5  Instr_IFID[25:21].
RtAddr_IFID  out  5  Instr_IFID[20:16].
FetchBusy  out  1  1 while waiting on memory (REQ with ImemRdy=0, or DROP).

Behaviour:
- Reset (async, any state): PC=RESET_PC, state=REQ, Instr_IFID=NOP_INSTR, PCPlus4_IFID=0, Valid_IFID=0, buffer empty, pending PC=0. ImemReq=0 while reset is high; ImemReq=1 from the first cycle after deassertion.
- advance = PCWre & ~IFID_Stall. PCWre=1 with IFID_Stall=1, or the reverse, is treated as a stall.
- Memory protocol: ImemAddr comes from a registered fetch-address register. It must not change between issue and ImemRdy. Zero-wait memory (ImemRdy in the same cycle) is legal, giving a throughput of 1 instr/cycle.
- REQ state (ImemReq=1, ImemAddr=PC):
  - ImemRdy & Redirect: discard data; PC<=RedirectPC; IF/ID<=bubble; stay in REQ.
  - ImemRdy & advance: IF/ID<={ImemData, PC+4, valid}; PC<=PC+4; stay in REQ.
  - ImemRdy & ~advance: capture ImemData/PC+4 into the buffer; go to BUF.
  - ~ImemRdy & Redirect: pending<=RedirectPC; IF/ID<=bubble; go to DROP.
  - ~ImemRdy & advance: IF/ID<=bubble.
  - ~ImemRdy & ~advance: IF/ID held.
- BUF state (ImemReq=0):
  - Redirect: discard buffer; PC<=RedirectPC; IF/ID<=bubble; go to REQ.
  - advance: IF/ID<=buffer; PC<=PC+4; go to REQ.
  - Otherwise: hold.
- DROP state (ImemReq=1, old ImemAddr held):
  - A further Redirect overwrites pending; the latest redirect wins.
  - On ImemRdy: discard data; PC<=pending; go to REQ.
  - IF/ID<=bubble whenever advance=1.
- Priority: reset > Redirect > stall > advance. Redirect flushes IF/ID even when IFID_Stall=1.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. PCPlus4_IFID is the fetched instruction's PC+4, not the current PC.
- Decoded field outputs are pure slices of Instr_IFID. A bubble therefore presents Rs=Rt=0, Opcode=0, Func=0.
- Only one request is outstanding at a time. ImemReq is never asserted in BUF.

Test Plan:
- Reset, then zero-wait memory returning 32'h2008_0005 at RESET_PC -> next edge Instr_IFID=32'h2008_0005, PCPlus4_IFID=32'h0000_3004, Valid_IFID=1; ImemAddr steps 3000, 3004, 3008 on consecutive cycles.
- 3-cycle memory latency -> FetchBusy=1 for 2 cycles, ImemAddr stable at 32'h0000_3004, Valid_IFID=0 bubbles in between, no address skipped.
- IFID_Stall=PCWre=0 for 2 cycles as ImemRdy arrives -> state BUF, ImemReq=0, IF/ID unchanged; on release the buffered word appears, then fetch resumes at +4 with no refetch of the same address.
- Redirect=1, RedirectPC=32'h0000_3043 while a 2-cycle fetch of 32'h0000_3010 is outstanding -> DROP state, 3010's data discarded, next ImemAddr=32'h0000_3040, IF/ID bubble.
- Two redirects in DROP (to 3100 and then 3200) -> fetch resumes at 32'h0000_3200; Redirect together with IFID_Stall=1 -> Valid_IFID=0 next cycle.
- Reset asserted mid-DROP and mid-BUF -> outputs go immediately to their reset values; after release the first ImemAddr is RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency instruction
// memory, and drives the IF/ID register with stall buffering and redirect flushing.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWre,
    input  logic        IFID_Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemRdy,
    input  logic [31:0] ImemData,
    output logic [31:0] Instr_IFID,
    output logic [31:0] PCPlus4_IFID,
    output logic        Valid_IFID,
    output logic [5:0]  Opcode_IFID,
    output logic [5:0]  Func_IFID,
    output logic [4:0]  RsAddr_IFID,
    output logic [4:0]  RtAddr_IFID,
    output logic        FetchBusy
);

    // state | meaning
    // REQ   | request outstanding at pc (zero-wait returns complete here)
    // BUF   | word returned while ID stalled; held in buf_instr, no request
    // DROP  | redirected while a request was in flight; waiting to discard it
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_BUF  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pending;
    logic [31:0] pending_next;
    logic [31:0] buf_instr;
    logic [31:0] buf_instr_next;
    logic [31:0] instr_next;
    logic [31:0] pc4_next;
    logic        valid_next;
    logic        bubble;

    logic        advance;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign advance  = PCWre & ~IFID_Stall;
    assign target   = {RedirectPC[31:2], 2'b00};
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        pending_next   = pending;
        buf_instr_next = buf_instr;
        instr_next     = Instr_IFID;
        pc4_next       = PCPlus4_IFID;
        valid_next     = Valid_IFID;
        bubble         = 1'b0;

        case (state)
            S_REQ: begin
                if (ImemRdy) begin
                    if (Redirect) begin
                        pc_next = target;
                        bubble  = 1'b1;
                    end else if (advance) begin
                        instr_next = ImemData;
                        pc4_next   = pc_plus4;
                        valid_next = 1'b1;
                        pc_next    = pc_plus4;
                    end else begin
                        // pc stays on the fetched address, so pc+4 is recovered on release
                        buf_instr_next = ImemData;
                        state_next     = S_BUF;
                    end
                end else begin
                    if (Redirect) begin
                        pending_next = target;
                        bubble       = 1'b1;
                        state_next   = S_DROP;
                    end else if (advance) begin
                        bubble = 1'b1;
                    end
                end
            end

            S_BUF: begin
                if (Redirect) begin
                    pc_next    = target;
                    bubble     = 1'b1;
                    state_next = S_REQ;
                end else if (advance) begin
                    instr_next = buf_instr;
                    pc4_next   = pc_plus4;
                    valid_next = 1'b1;
                    pc_next    = pc_plus4;
                    state_next = S_REQ;
                end
            end

            S_DROP: begin
                if (Redirect) begin
                    pending_next = target;
                end
                if (Redirect || advance) begin
                    bubble = 1'b1;
                end
                if (ImemRdy) begin
                    pc_next    = Redirect ? target : pending;
                    state_next = S_REQ;
                end
            end

            default: begin
                state_next = S_REQ;
            end
        endcase

        if (bubble) begin
            instr_next = NOP_INSTR;
            pc4_next   = 32'd0;
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            pending      <= 32'd0;
            buf_instr    <= 32'd0;
            Instr_IFID   <= NOP_INSTR;
            PCPlus4_IFID <= 32'd0;
            Valid_IFID   <= 1'b0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            pending      <= pending_next;
            buf_instr    <= buf_instr_next;
            Instr_IFID   <= instr_next;
            PCPlus4_IFID <= pc4_next;
            Valid_IFID   <= valid_next;
        end
    end

    // pc doubles as the fetch-address register; it only moves on a completed request
    assign ImemAddr  = pc;
    assign ImemReq   = ~reset & (state != S_BUF);
    assign FetchBusy = ~reset & (((state == S_REQ) & ~ImemRdy) | (state == S_DROP));

    assign Opcode_IFID = Instr_IFID[31:26];
    assign RsAddr_IFID = Instr_IFID[25:21];
    assign RtAddr_IFID = Instr_IFID[20:16];
    assign Func_IFID   = Instr_IFID[5:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: hand-computed expectations for fetch, latency,
// stall buffering, redirects, PC wrap and asynchronous reset.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        PCWre;
    logic        IFID_Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemRdy;
    logic [31:0] ImemData;
    logic [31:0] Instr_IFID;
    logic [31:0] PCPlus4_IFID;
    logic        Valid_IFID;
    logic [5:0]  Opcode_IFID;
    logic [5:0]  Func_IFID;
    logic [4:0]  RsAddr_IFID;
    logic [4:0]  RtAddr_IFID;
    logic        FetchBusy;

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .PCWre        (PCWre),
        .IFID_Stall   (IFID_Stall),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .ImemReq      (ImemReq),
        .ImemAddr     (ImemAddr),
        .ImemRdy      (ImemRdy),
        .ImemData     (ImemData),
        .Instr_IFID   (Instr_IFID),
        .PCPlus4_IFID (PCPlus4_IFID),
        .Valid_IFID   (Valid_IFID),
        .Opcode_IFID  (Opcode_IFID),
        .Func_IFID    (Func_IFID),
        .RsAddr_IFID  (RsAddr_IFID),
        .RtAddr_IFID  (RtAddr_IFID),
        .FetchBusy    (FetchBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // registered IF/ID contents plus the current fetch address
    task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                            input logic valid, input logic [31:0] addr);
        chk({tag, "_instr"}, Instr_IFID, instr);
        chk({tag, "_pc4"}, PCPlus4_IFID, pc4);
        chk({tag, "_valid"}, {31'd0, Valid_IFID}, {31'd0, valid});
        chk({tag, "_addr"}, ImemAddr, addr);
    endtask

    initial begin
        reset      = 1'b1;
        PCWre      = 1'b1;
        IFID_Stall = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = 32'd0;
        ImemRdy    = 1'b0;
        ImemData   = 32'd0;

        tick();
        tick();
        chk_ifid("rst", 32'h0, 32'h0, 1'b0, 32'h0000_3000);
        chk("rst_req", {31'd0, ImemReq}, 32'd0);
        chk("rst_busy", {31'd0, FetchBusy}, 32'd0);

        // zero-wait fetch at RESET_PC
        reset    = 1'b0;
        ImemRdy  = 1'b1;
        ImemData = 32'h2008_0005;
        #1;
        chk("zw_req", {31'd0, ImemReq}, 32'd1);
        chk("zw_busy", {31'd0, FetchBusy}, 32'd0);
        chk("zw_addr0", ImemAddr, 32'h0000_3000);
        tick();
        chk_ifid("zw1", 32'h2008_0005, 32'h0000_3004, 1'b1, 32'h0000_3004);
        chk("zw1_op", {26'd0, Opcode_IFID}, 32'h08);
        chk("zw1_rs", {27'd0, RsAddr_IFID}, 32'h00);
        chk("zw1_rt", {27'd0, RtAddr_IFID}, 32'h08);
        chk("zw1_fn", {26'd0, Func_IFID}, 32'h05);

        // 3-cycle latency fetch of 3004
        ImemRdy = 1'b0;
        #1;
        chk("lat_busy0", {31'd0, FetchBusy}, 32'd1);
        tick();
        chk_ifid("lat1", 32'h0, 32'h0, 1'b0, 32'h0000_3004);
        chk("lat1_busy", {31'd0, FetchBusy}, 32'd1);
        tick();
        chk_ifid("lat2", 32'h0, 32'h0, 1'b0, 32'h0000_3004);
        ImemRdy  = 1'b1;
        ImemData = 32'h8C09_0004;
        #1;
        chk("lat_busy_rdy", {31'd0, FetchBusy}, 32'd0);
        tick();
        chk_ifid("lat3", 32'h8C09_0004, 32'h0000_3008, 1'b1, 32'h0000_3008);
        chk("lat3_op", {26'd0, Opcode_IFID}, 32'h23);
        chk("lat3_rt", {27'd0, RtAddr_IFID}, 32'h09);
        chk("lat3_fn", {26'd0, Func_IFID}, 32'h04);

        // word for 3008 arrives while ID is stalled -> buffered
        PCWre    = 1'b0;
        ImemData = 32'h0109_5020;
        tick();
        ImemRdy  = 1'b0;
        ImemData = 32'hBAD0_BAD0;
        #1;
        chk_ifid("buf1", 32'h8C09_0004, 32'h0000_3008, 1'b1, 32'h0000_3008);
        chk("buf1_req", {31'd0, ImemReq}, 32'd0);
        chk("buf1_busy", {31'd0, FetchBusy}, 32'd0);
        tick();
        chk_ifid("buf2", 32'h8C09_0004, 32'h0000_3008, 1'b1, 32'h0000_3008);
        chk("buf2_req", {31'd0, ImemReq}, 32'd0);
        PCWre = 1'b1;
        tick();
        chk_ifid("buf_rel", 32'h0109_5020, 32'h0000_300C, 1'b1, 32'h0000_300C);
        chk("buf_rel_req", {31'd0, ImemReq}, 32'd1);

        // fetch 300C, then redirect while 3010 is outstanding
        ImemRdy  = 1'b1;
        ImemData = 32'h2129_0001;
        tick();
        chk_ifid("pre_rd", 32'h2129_0001, 32'h0000_3010, 1'b1, 32'h0000_3010);
        ImemRdy    = 1'b0;
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_3043;
        tick();
        chk_ifid("drop1", 32'h0, 32'h0, 1'b0, 32'h0000_3010);
        Redirect = 1'b0;
        #1;
        chk("drop1_busy", {31'd0, FetchBusy}, 32'd1);
        chk("drop1_req", {31'd0, ImemReq}, 32'd1);
        ImemRdy  = 1'b1;
        ImemData = 32'hDEAD_BEEF;
        tick();
        chk_ifid("drop_done", 32'h0, 32'h0, 1'b0, 32'h0000_3040);

        // two redirects inside DROP; the later one wins
        ImemRdy    = 1'b0;
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_3100;
        tick();
        chk("dd1_addr", ImemAddr, 32'h0000_3040);
        RedirectPC = 32'h0000_3200;
        tick();
        chk("dd2_addr", ImemAddr, 32'h0000_3040);
        Redirect = 1'b0;
        ImemRdy  = 1'b1;
        ImemData = 32'hDEAD_BEEF;
        tick();
        chk_ifid("dd_done", 32'h0, 32'h0, 1'b0, 32'h0000_3200);

        // redirect overrides IFID_Stall
        ImemData = 32'h1234_5678;
        tick();
        chk_ifid("pre_rs", 32'h1234_5678, 32'h0000_3204, 1'b1, 32'h0000_3204);
        IFID_Stall = 1'b1;
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_3300;
        ImemData   = 32'hDEAD_BEEF;
        tick();
        chk_ifid("rd_stall", 32'h0, 32'h0, 1'b0, 32'h0000_3300);

        // redirect with low bits set to the top word, then wrap of PC+4
        IFID_Stall = 1'b0;
        RedirectPC = 32'hFFFF_FFFF;
        tick();
        chk("wrap_addr", ImemAddr, 32'hFFFF_FFFC);
        Redirect = 1'b0;
        ImemData = 32'hAAAA_5555;
        tick();
        chk_ifid("wrap", 32'hAAAA_5555, 32'h0000_0000, 1'b1, 32'h0000_0000);

        // reset asserted mid-DROP
        ImemRdy    = 1'b0;
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_3400;
        tick();
        chk("mdrop_busy", {31'd0, FetchBusy}, 32'd1);
        Redirect = 1'b0;
        reset    = 1'b1;
        #1;
        chk_ifid("rst_drop", 32'h0, 32'h0, 1'b0, 32'h0000_3000);
        chk("rst_drop_req", {31'd0, ImemReq}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rel_drop_req", {31'd0, ImemReq}, 32'd1);
        chk("rel_drop_addr", ImemAddr, 32'h0000_3000);

        // reset asserted mid-BUF
        ImemRdy  = 1'b1;
        ImemData = 32'h0000_0020;
        tick();
        chk_ifid("mbuf_pre", 32'h0000_0020, 32'h0000_3004, 1'b1, 32'h0000_3004);
        PCWre    = 1'b0;
        ImemData = 32'h1111_2222;
        tick();
        chk("mbuf_req", {31'd0, ImemReq}, 32'd0);
        reset = 1'b1;
        #1;
        chk_ifid("rst_buf", 32'h0, 32'h0, 1'b0, 32'h0000_3000);
        tick();
        reset    = 1'b0;
        PCWre    = 1'b1;
        ImemData = 32'h2008_0005;
        #1;
        chk("rel_buf_req", {31'd0, ImemReq}, 32'd1);
        tick();
        chk_ifid("rel_buf", 32'h2008_0005, 32'h0000_3004, 1'b1, 32'h0000_3004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
